window_line_accumulator: RTL
============================

Name: window_line_accumulator

Overview:
- Sits directly downstream of the per-line template datapath.
- Consumes one row of line sums per accepted beat: sum of I squared, sum of I, and one T×I sum per template.
- Keeps a sliding vertical window of the last NUM_OF_LINES rows and produces full-window sums plus the index of the best-matching template.
- Feeds the normalisation/score stage through a valid/ready handshake.

Parameters:
- PIXEL_SIZE, 8, pixel width in bits.
- NUM_TEMPLATES, 2, number of templates correlated in parallel.
- LINE_SIZE, 5, pixels per window line.
- NUM_OF_LINES, 5, lines per window (window height).
- LSUM_W, $clog2(LINE_SIZE)+2*PIXEL_SIZE (=19), width of incoming line sums.
- ACC_W, LSUM_W+$clog2(NUM_OF_LINES) (=22), width of window sums.
- IDX_W, max(1,$clog2(NUM_TEMPLATES)), width of best_template.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_valid  in  1  line sums valid this cycle.
- in_ready  out  1  block can accept a line.
- frame_start  in  1  qualified by in_valid; this line is row 0 of a new frame.
- I_square_line_sum  in  LSUM_W  line sum of I squared.
- I_line_sum  in  LSUM_W  line sum of I.
- T_x_I_line_sum[NUM_TEMPLATES]  in  LSUM_W each  per-template line sum of T×I.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- I_square_win_sum  out  ACC_W  window sum of I squared.
- I_win_sum  out  ACC_W  window sum of I.
- T_x_I_win_sum[NUM_TEMPLATES]  out  ACC_W each  per-template window sum of T×I.
- best_template  out  IDX_W  index of the largest T_x_I_win_sum.

Behaviour:
- Clocking and reset: single clock CLK; RST_N is synchronous, active-low.
- Reset clears all history, accumulators, fill_cnt and output registers to 0, clears out_valid, and sets state to FILL.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A line is accepted when in_valid && in_ready.
  - Inputs are ignored when no line is accepted.
- History: per sum stream, a shift register of depth NUM_OF_LINES holding line sums; 2+NUM_TEMPLATES streams in total.
- Accumulator update on accept: acc <= acc + new - oldest, where oldest is the entry shifted out. Entries not yet written read as 0.
- Arithmetic is unsigned. Accumulators are exact, with no wrap: max window value 25×255² = 1,625,625 < 2^ACC_W.
- fill_cnt counts 0..NUM_OF_LINES and saturates.
- State machine, 2 states:
  - FILL (fill_cnt < NUM_OF_LINES): accepts update the history but produce no output.
  - RUN (fill_cnt == NUM_OF_LINES): every accept produces a result.
  - FILL -> RUN on the accept that brings fill_cnt to NUM_OF_LINES.
  - RUN -> FILL only on frame_start or reset.
- frame_start on an accepted line:
  - Clears history and accumulators before adding the line, so the window holds only this line; fill_cnt = 1; state = FILL.
  - If NUM_OF_LINES == 1, go directly to RUN and produce a result.
- Output latency:
  - Window sums for the accepting line appear on the outputs with out_valid=1 in the cycle after the accept, i.e. they are registered.
  - The result includes that line.
- Output hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Back-to-back: with out_ready=1 held, one line per cycle is accepted and one result per cycle is produced in RUN.
- out_valid clear: out_valid drops on the cycle after a transfer (out_valid && out_ready) if no new result is loaded. A simultaneous transfer and new accept reloads the output register, and out_valid stays 1.
- best_template:
  - Computed from the new window sums and registered together with them.
  - Ties resolve to the lowest index.
  - Holds 0 when NUM_TEMPLATES == 1.
- Reset mid-operation: a partial window is discarded; the next 5 accepted lines are needed before any output.
- No output is ever produced from a window spanning a frame_start boundary.

Test Plan:
- Uniform pixels: every line has I_line_sum=50, I_square_line_sum=500, T_x_I={100,200}; feed 5 lines -> first out_valid one cycle after the 5th accept with I_win_sum=250, I_square_win_sum=2500, T_x_I_win_sum={500,1000}, best_template=1. No out_valid during lines 1-4.
- Sliding window: I_line_sum = 1,2,3,4,5,6,7 on consecutive cycles with out_ready=1 -> I_win_sum outputs 15, 20, 25 on consecutive cycles.
- Backpressure: in RUN, drop out_ready for 3 cycles -> in_ready=0, outputs frozen, no line lost. After out_ready returns, the next held line's result equals its correct window sum.
- frame_start mid-stream: after 7 lines, assert frame_start on line 8 with value 9 -> no out_valid until line 12 accepted. Then I_win_sum = sum of lines 8..12 only.
- Reset mid-window: after 3 lines, pull RST_N low for 1 cycle -> outputs 0, out_valid=0. The next 5 lines of value 4 give I_win_sum=20.
- Template tie and max values:
  - T_x_I line sums {300,300} -> best_template=0.
  - All inputs at max (I_square_line_sum=325125) for 5 lines -> I_square_win_sum=1625625 with no wrap.

Source files
------------

// File: rtl/window_line_accumulator.sv
// Sliding vertical window over per-line template sums: keeps the last NUM_OF_LINES
// rows per stream, emits full-window sums and the best-matching template index.
module window_line_accumulator #(
   parameter int unsigned PIXEL_SIZE    = 8,
   parameter int unsigned NUM_TEMPLATES = 2,
   parameter int unsigned LINE_SIZE     = 5,
   parameter int unsigned NUM_OF_LINES  = 5,
   parameter int unsigned LSUM_W        = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
   parameter int unsigned ACC_W         = LSUM_W + $clog2(NUM_OF_LINES),
   parameter int unsigned IDX_W         = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              frame_start,
   input  logic [LSUM_W-1:0] I_square_line_sum,
   input  logic [LSUM_W-1:0] I_line_sum,
   input  logic [LSUM_W-1:0] T_x_I_line_sum [NUM_TEMPLATES],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  I_square_win_sum,
   output logic [ACC_W-1:0]  I_win_sum,
   output logic [ACC_W-1:0]  T_x_I_win_sum [NUM_TEMPLATES],
   output logic [IDX_W-1:0]  best_template
);

   localparam int unsigned NUM_STREAMS = 2 + NUM_TEMPLATES;
   localparam int unsigned FILL_W      = $clog2(NUM_OF_LINES + 1);

   typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              r_state;
   logic [FILL_W-1:0]   r_fill_cnt;
   logic [LSUM_W-1:0]   r_hist [NUM_STREAMS][NUM_OF_LINES];
   logic [ACC_W-1:0]    r_acc  [NUM_STREAMS];
   logic                r_out_valid;
   logic [ACC_W-1:0]    r_win  [NUM_STREAMS];
   logic [IDX_W-1:0]    r_best;

   logic                w_accept;
   logic                w_produce;
   logic [FILL_W-1:0]   w_fill_next;
   logic [LSUM_W-1:0]   w_new      [NUM_STREAMS];
   logic [ACC_W-1:0]    w_acc_next [NUM_STREAMS];
   logic [ACC_W-1:0]    w_best_val;
   logic [IDX_W-1:0]    w_best_idx;

   assign in_ready         = !r_out_valid || out_ready;
   assign out_valid        = r_out_valid;
   assign I_square_win_sum = r_win[0];
   assign I_win_sum        = r_win[1];
   assign best_template    = r_best;

   for (genvar g = 0; g < NUM_TEMPLATES; g++) begin : g_out
      assign T_x_I_win_sum[g] = r_win[2+g];
   end

   // Stream 0 = I^2, stream 1 = I, streams 2.. = T x I per template
   always_comb begin
      w_accept = in_valid && in_ready;
      w_new[0] = I_square_line_sum;
      w_new[1] = I_line_sum;
      for (int unsigned t = 0; t < NUM_TEMPLATES; t++) begin
         w_new[2+t] = T_x_I_line_sum[t];
      end
   end

   // New window sums; a frame start restarts the window from this line alone
   always_comb begin
      for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
         if (frame_start) begin
            w_acc_next[s] = ACC_W'(w_new[s]);
         end else begin
            w_acc_next[s] = r_acc[s] + ACC_W'(w_new[s])
                          - ACC_W'(r_hist[s][NUM_OF_LINES-1]);
         end
      end
   end

   always_comb begin
      if (frame_start) begin
         w_fill_next = FILL_W'(1);
      end else if (r_state == ST_RUN || r_fill_cnt == FILL_W'(NUM_OF_LINES)) begin
         w_fill_next = FILL_W'(NUM_OF_LINES);
      end else begin
         w_fill_next = r_fill_cnt + FILL_W'(1);
      end
      w_produce = w_accept && (w_fill_next == FILL_W'(NUM_OF_LINES));
   end

   // Strict greater-than keeps ties on the lowest index
   always_comb begin
      w_best_idx = '0;
      w_best_val = w_acc_next[2];
      for (int unsigned t = 1; t < NUM_TEMPLATES; t++) begin
         if (w_acc_next[2+t] > w_best_val) begin
            w_best_val = w_acc_next[2+t];
            w_best_idx = IDX_W'(t);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= ST_FILL;
         r_fill_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_best      <= '0;
         for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
            r_acc[s] <= '0;
            r_win[s] <= '0;
            for (int unsigned k = 0; k < NUM_OF_LINES; k++) begin
               r_hist[s][k] <= '0;
            end
         end
      end else begin
         if (w_accept) begin
            for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
               for (int unsigned k = 1; k < NUM_OF_LINES; k++) begin
                  r_hist[s][k] <= frame_start ? '0 : r_hist[s][k-1];
               end
               r_hist[s][0] <= w_new[s];
               r_acc[s]     <= w_acc_next[s];
            end
            r_fill_cnt <= w_fill_next;
            r_state    <= (w_fill_next == FILL_W'(NUM_OF_LINES)) ? ST_RUN : ST_FILL;
         end

         if (w_produce) begin
            r_out_valid <= 1'b1;
            r_best      <= w_best_idx;
            for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
               r_win[s] <= w_acc_next[s];
            end
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
